reg_bank_ctrl: RTL and testbench

Parametrised register bank with a command-driven transfer controller: a general-purpose register file of NREGS entries of WIDTH bits, updated by sequenced IN / MOVE / SWAP / READ commands over a valid/ready handshake. It replaces the fixed 8×16 MOVE/IN control register:
- the separate MOVE/IN strobes become an encoded op, so the old "both strobes high" conflict cannot occur;
- a 3-step SWAP through an internal temporary register is added;
- out-of-range indices are flagged.

It sits between the datapath sequencer, which issues commands, and the bus that consumes data_out.

---
 rtl/reg_bank_ctrl_if.sv | 28 ++
 rtl/reg_bank_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_reg_bank_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_ctrl_if.sv
// Command/response bus between the datapath sequencer (master) and the
// register bank controller (slave).
interface reg_bank_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       op;
  logic [AW-1:0]    src;
  logic [AW-1:0]    dest;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, op, src, dest, data_in,
    input  cmd_ready, data_out, done, err
  );

  modport slave (
    input  cmd_valid, op, src, dest, data_in,
    output cmd_ready, data_out, done, err
  );
endinterface

// File: rtl/reg_bank_ctrl.sv
// Register bank of NREGS x WIDTH driven by IN / MOVE / SWAP / READ commands;
// SWAP runs in three steps through an internal temporary register.
module reg_bank_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input logic           clk,
  input logic           rst,
  reg_bank_ctrl_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  localparam logic [1:0] OP_IN   = 2'b00;
  localparam logic [1:0] OP_MOVE = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, SWAP2, SWAP3} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [AW-1:0]    src_reg, dest_reg;
  logic [WIDTH-1:0] din_reg;
  logic [WIDTH-1:0] tmp_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic             done_reg, err_reg;
  logic [WIDTH-1:0] regs [NREGS];

  logic             cmd_ready_int;
  logic             accept;
  logic             src_ok, dest_ok, cmd_ok;
  logic [WIDTH-1:0] src_val, dest_val;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [NREGS-1:0] wr_sel;
  logic             tmp_load;
  logic             dout_load;
  logic [WIDTH-1:0] dout_val;
  logic             done_next, err_next;

  // Ready is gated by rst directly so it is low for the whole reset window.
  assign cmd_ready_int = (state_reg == IDLE) && !rst;
  assign accept        = bus.cmd_valid && cmd_ready_int;

  assign src_ok  = {1'b0, src_reg}  < NREGS_W;
  assign dest_ok = {1'b0, dest_reg} < NREGS_W;

  always_comb begin
    cmd_ok = 1'b0;
    case (op_reg)
      OP_IN:   cmd_ok = dest_ok;
      OP_READ: cmd_ok = src_ok;
      default: cmd_ok = src_ok && dest_ok;
    endcase
  end

  assign src_val  = src_ok  ? regs[src_reg]  : '0;
  assign dest_val = dest_ok ? regs[dest_reg] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg   <= OP_IN;
      src_reg  <= '0;
      dest_reg <= '0;
      din_reg  <= '0;
    end else if (accept) begin
      op_reg   <= bus.op;
      src_reg  <= bus.src;
      dest_reg <= bus.dest;
      din_reg  <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = (cmd_ok && op_reg == OP_SWAP) ? SWAP2 : IDLE;
      SWAP2:   state_next = SWAP3;
      SWAP3:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Illegal commands complete straight from EXEC without touching any state.
  always_comb begin
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    tmp_load  = 1'b0;
    dout_load = 1'b0;
    dout_val  = '0;
    done_next = 1'b0;
    err_next  = 1'b0;
    case (state_reg)
      EXEC: begin
        done_next = !(cmd_ok && op_reg == OP_SWAP);
        err_next  = !cmd_ok;
        if (cmd_ok) begin
          case (op_reg)
            OP_IN: begin
              wr_en     = 1'b1;
              wr_idx    = dest_reg;
              wr_data   = din_reg;
              dout_load = 1'b1;
              dout_val  = din_reg;
            end
            OP_MOVE: begin
              wr_en     = 1'b1;
              wr_idx    = dest_reg;
              wr_data   = src_val;
              dout_load = 1'b1;
              dout_val  = src_val;
            end
            OP_READ: begin
              dout_load = 1'b1;
              dout_val  = src_val;
            end
            default: tmp_load = 1'b1;
          endcase
        end
      end
      SWAP2: begin
        wr_en   = 1'b1;
        wr_idx  = src_reg;
        wr_data = dest_val;
      end
      SWAP3: begin
        wr_en     = 1'b1;
        wr_idx    = dest_reg;
        wr_data   = tmp_reg;
        dout_load = 1'b1;
        dout_val  = tmp_reg;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmp_reg      <= '0;
      data_out_reg <= '0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (tmp_load)  tmp_reg      <= src_val;
      if (dout_load) data_out_reg <= dout_val;
      done_reg <= done_next;
      err_reg  <= err_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (wr_idx == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst) begin
        regs[i] <= '0;
      end else if (wr_sel[i]) begin
        regs[i] <= wr_data;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_int;
  assign bus.data_out  = data_out_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed plus randomized command sequence against an array-based model of
// the register bank; NREGS=6 so indices 6 and 7 exercise the illegal path.
module tb_reg_bank_ctrl;
  localparam int WIDTH = 16;
  localparam int NREGS = 6;
  localparam logic [1:0] IN = 2'b00, MOVE = 2'b01, SWAP = 2'b10, READ = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_bank_ctrl_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus();
  reg_bank_ctrl #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [WIDTH-1:0] model_r [NREGS];
  logic [WIDTH-1:0] model_dout;
  int prev_acc;
  int prev_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) model_r[i] = '0;
    model_dout = '0;
  endtask

  // Called just after a negedge; returns at the negedge of the done cycle.
  task automatic do_cmd(input logic [1:0] op, input int src, input int dest,
                        input logic [WIDTH-1:0] din, input bit hold, input bit b2b);
    bit legal;
    logic [WIDTH-1:0] exp_dout;
    logic [WIDTH-1:0] t;
    int lat, k, waited, acc;
    if (op == IN)        legal = (dest < NREGS);
    else if (op == READ) legal = (src < NREGS);
    else                 legal = (src < NREGS) && (dest < NREGS);
    if (!legal)          exp_dout = model_dout;
    else if (op == IN)   exp_dout = din;
    else                 exp_dout = model_r[src];
    lat = (legal && op == SWAP) ? 4 : 2;

    bus.cmd_valid = 1'b1;
    bus.op        = op;
    bus.src       = 3'(src);
    bus.dest      = 3'(dest);
    bus.data_in   = din;
    waited = 0;
    while (bus.cmd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_wait", 32'(waited < 20), 1);
    if (waited >= 20) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc = cycle;
    if (!hold) bus.cmd_valid = 1'b0;
    if (b2b) chk("accept_spacing", 32'(acc - prev_acc), 32'(prev_lat));

    k = 1;
    while (bus.done !== 1'b1 && k < 10) begin
      chk("busy_ready_low", 32'(bus.cmd_ready), 0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(lat));
    chk("err", 32'(bus.err), 32'(!legal));
    chk("data_out", 32'(bus.data_out), 32'(exp_dout));
    chk("ready_at_done", 32'(bus.cmd_ready), 1);

    if (legal) begin
      case (op)
        IN:   model_r[dest] = din;
        MOVE: model_r[dest] = model_r[src];
        SWAP: begin
          t             = model_r[src];
          model_r[src]  = model_r[dest];
          model_r[dest] = t;
        end
        default: ;
      endcase
    end
    model_dout = exp_dout;
    prev_acc   = acc;
    prev_lat   = lat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    int rs, rd;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.op        = IN;
    bus.src       = '0;
    bus.dest      = '0;
    bus.data_in   = '0;
    model_clear();
    prev_acc = 0;
    prev_lat = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.cmd_ready), 1);

    do_cmd(IN, 0, 0, 16'd9, 0, 0);
    do_cmd(READ, 0, 0, 16'd0, 0, 1);
    do_cmd(MOVE, 0, 1, 16'd0, 0, 1);
    do_cmd(IN, 0, 2, 16'd15, 0, 1);
    do_cmd(MOVE, 2, 0, 16'd0, 0, 1);
    do_cmd(READ, 0, 0, 16'd0, 0, 1);
    do_cmd(READ, 1, 0, 16'd0, 0, 1);
    do_cmd(READ, 2, 0, 16'd0, 0, 1);
    do_cmd(IN, 0, 3, 16'hAAAA, 0, 1);
    do_cmd(IN, 0, 5, 16'h5555, 0, 1);
    do_cmd(SWAP, 3, 5, 16'd0, 0, 1);
    do_cmd(READ, 3, 0, 16'd0, 0, 1);
    do_cmd(READ, 5, 0, 16'd0, 0, 1);
    do_cmd(IN, 0, 7, 16'h1234, 0, 1);
    do_cmd(MOVE, 6, 0, 16'd0, 0, 1);
    do_cmd(READ, 0, 0, 16'd0, 0, 1);
    do_cmd(MOVE, 1, 1, 16'd0, 0, 1);
    do_cmd(SWAP, 2, 2, 16'd0, 0, 1);
    do_cmd(READ, 2, 0, 16'd0, 0, 1);
    do_cmd(IN, 0, 4, 16'h0BEE, 1, 1);
    do_cmd(IN, 0, 1, 16'hC0DE, 1, 1);
    do_cmd(READ, 4, 0, 16'd0, 0, 1);

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      rs  = $urandom_range(0, 7);
      rd  = $urandom_range(0, 7);
      do_cmd(rop, rs, rd, 16'($urandom), 1'($urandom_range(0, 1)), 1);
    end

    // Abort a SWAP while it sits in its second step.
    bus.cmd_valid = 1'b1;
    bus.op        = SWAP;
    bus.src       = 3'd3;
    bus.dest      = 3'd5;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 0);
      chk("abort_ready_low", 32'(bus.cmd_ready), 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", 32'(bus.cmd_ready), 1);
    chk("abort_data_out", 32'(bus.data_out), 0);
    chk("abort_no_done_after", 32'(bus.done), 0);
    model_clear();
    do_cmd(READ, 0, 0, 16'd0, 0, 0);
    for (int i = 1; i < NREGS; i++) do_cmd(READ, i, 0, 16'd0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
